controlador_turnos: RTL and testbench

Top-level game sequencer for the two-player board game. It starts `inicializador_juego`, takes the starting player it returns, and alternates turns between players. Each turn has a per-turn countdown. On every move it consults the board checker and declares a winner or a draw. It sits between the input/VGA front end and the board/checker datapath.

---
 rtl/juego_pkg.sv | 38 +++
 rtl/temporizador_turno.sv | 65 ++++++
 rtl/controlador_turnos.sv | 166 ++++++++++++++++
 tb/tb_controlador_turnos.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/juego_pkg.sv
// Shared types and constants for the two-player game sequencer.
//   estado_t               : sequencer states
//   GANADOR_*              : encodings of the ganador output
//   NUM_JUGADAS_W          : width of the completed-move counter
//   incrementar_saturado() : move counter increment that sticks at its maximum
//   ganador_de()           : winner code for a given player
package juego_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INICIALIZAR,
        ESPERAR_LISTO,
        TURNO,
        VERIFICAR,
        CAMBIO,
        FIN
    } estado_t;

    localparam logic [1:0] GANADOR_NINGUNO = 2'b00;
    localparam logic [1:0] GANADOR_J0      = 2'b01;
    localparam logic [1:0] GANADOR_J1      = 2'b10;
    localparam logic [1:0] GANADOR_EMPATE  = 2'b11;

    localparam int NUM_JUGADAS_W = 7;
    localparam logic [NUM_JUGADAS_W-1:0] NUM_JUGADAS_MAX = '1;

    function automatic logic [NUM_JUGADAS_W-1:0] incrementar_saturado(
        input logic [NUM_JUGADAS_W-1:0] n
    );
        return (n == NUM_JUGADAS_MAX) ? n : n + 1'b1;
    endfunction

    // Player 0 -> 01, player 1 -> 10.
    function automatic logic [1:0] ganador_de(input logic jugador);
        return {jugador, ~jugador};
    endfunction

endpackage

// File: rtl/temporizador_turno.sv
// Per-turn countdown: a prescaler dividing clk down to one tick per second
// and a seconds down-counter decremented on each tick.
// Ports:
//   clk, reset          : system clock, async active-high reset
//   cargar              : reload seconds to SEGUNDOS_TURNO and clear prescaler
//   habilitar           : let the prescaler run this cycle
//   segundos_restantes  : seconds left in the turn
//   expira              : the tick of this cycle takes the counter from 1 to 0
module temporizador_turno
    import juego_pkg::*;
#(
    parameter int CICLOS_POR_SEG = 50_000_000,
    parameter int SEGUNDOS_TURNO = 10
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    cargar,
    input  logic                                    habilitar,
    output logic [$clog2(SEGUNDOS_TURNO+1)-1:0]     segundos_restantes,
    output logic                                    expira
);

    localparam int SEG_W = $clog2(SEGUNDOS_TURNO + 1);
    localparam int PRE_W = (CICLOS_POR_SEG > 1) ? $clog2(CICLOS_POR_SEG) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CICLOS_POR_SEG - 1);
    localparam logic [SEG_W-1:0] SEG_INI = SEG_W'(SEGUNDOS_TURNO);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic             tick;

    assign tick = habilitar && (pre_q == PRE_MAX);

    always_comb begin
        pre_d = pre_q;
        seg_d = seg_q;
        if (cargar) begin
            pre_d = '0;
            seg_d = SEG_INI;
        end else if (habilitar) begin
            if (tick) begin
                pre_d = '0;
                if (seg_q != '0) begin
                    seg_d = seg_q - 1'b1;
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
            seg_q <= '0;
        end else begin
            pre_q <= pre_d;
            seg_q <= seg_d;
        end
    end

    assign segundos_restantes = seg_q;
    assign expira             = tick && !cargar && (seg_q == SEG_W'(1));

endmodule

// File: rtl/controlador_turnos.sv
// Game sequencer: starts the initializer, takes the starting player, then
// alternates turns with a per-turn countdown, asks the board checker after
// every move and declares a winner or a draw.
// Ports:
//   clk, reset          : system clock, async active-high reset
//   start_juego         : request a new game (from IDLE or FIN)
//   start_inicial       : one-cycle start pulse to the initializer
//   listo               : initializer done
//   jugador_inicial     : starting player, valid with listo
//   jugada_hecha        : current player placed a piece (one-cycle pulse)
//   hay_ganador         : checker says the last move wins
//   tablero_lleno       : checker says the board is full
//   jugador_actual      : player whose turn it is
//   habilitar_jugada    : moves accepted (TURNO)
//   segundos_restantes  : turn countdown
//   timeout             : one-cycle pulse when a turn expires
//   num_jugadas         : completed moves, saturating
//   fin_juego           : game over (FIN)
//   ganador             : 00 none, 01 player 0, 10 player 1, 11 draw
//
// state         | meaning
// --------------+------------------------------------------------------
// IDLE          | waiting for start_juego after reset
// INICIALIZAR   | start_inicial pulse, clear score of the previous game
// ESPERAR_LISTO | waiting for the initializer to return the first player
// TURNO         | current player may move, countdown running
// VERIFICAR     | one cycle to evaluate the checker after a move
// CAMBIO        | hand the turn to the other player, reload countdown
// FIN           | game over, results held until start_juego
module controlador_turnos
    import juego_pkg::*;
#(
    parameter int CICLOS_POR_SEG = 50_000_000,
    parameter int SEGUNDOS_TURNO = 10
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start_juego,
    output logic                                    start_inicial,
    input  logic                                    listo,
    input  logic                                    jugador_inicial,
    input  logic                                    jugada_hecha,
    input  logic                                    hay_ganador,
    input  logic                                    tablero_lleno,
    output logic                                    jugador_actual,
    output logic                                    habilitar_jugada,
    output logic [$clog2(SEGUNDOS_TURNO+1)-1:0]     segundos_restantes,
    output logic                                    timeout,
    output logic [NUM_JUGADAS_W-1:0]                num_jugadas,
    output logic                                    fin_juego,
    output logic [1:0]                              ganador
);

    estado_t                  estado_q, estado_d;
    logic                     jugador_q, jugador_d;
    logic [NUM_JUGADAS_W-1:0] num_q, num_d;
    logic [1:0]               ganador_q, ganador_d;
    logic                     timeout_q, timeout_d;

    logic cargar_tmr;
    logic habilitar_tmr;
    logic expira_tmr;

    temporizador_turno #(
        .CICLOS_POR_SEG (CICLOS_POR_SEG),
        .SEGUNDOS_TURNO (SEGUNDOS_TURNO)
    ) u_temporizador (
        .clk                (clk),
        .reset              (reset),
        .cargar             (cargar_tmr),
        .habilitar          (habilitar_tmr),
        .segundos_restantes (segundos_restantes),
        .expira             (expira_tmr)
    );

    always_comb begin
        estado_d      = estado_q;
        jugador_d     = jugador_q;
        num_d         = num_q;
        ganador_d     = ganador_q;
        timeout_d     = 1'b0;
        cargar_tmr    = 1'b0;
        habilitar_tmr = 1'b0;

        unique case (estado_q)
            IDLE: begin
                if (start_juego) begin
                    estado_d = INICIALIZAR;
                end
            end
            INICIALIZAR: begin
                num_d     = '0;
                ganador_d = GANADOR_NINGUNO;
                estado_d  = ESPERAR_LISTO;
            end
            ESPERAR_LISTO: begin
                if (listo) begin
                    jugador_d  = jugador_inicial;
                    cargar_tmr = 1'b1;
                    estado_d   = TURNO;
                end
            end
            TURNO: begin
                // A move on the expiring tick wins: the timer is frozen that
                // cycle so no expiry is seen.
                habilitar_tmr = !jugada_hecha;
                if (jugada_hecha) begin
                    num_d    = incrementar_saturado(num_q);
                    estado_d = VERIFICAR;
                end else if (expira_tmr) begin
                    timeout_d = 1'b1;
                    estado_d  = CAMBIO;
                end
            end
            VERIFICAR: begin
                if (hay_ganador) begin
                    ganador_d = ganador_de(jugador_q);
                    estado_d  = FIN;
                end else if (tablero_lleno) begin
                    ganador_d = GANADOR_EMPATE;
                    estado_d  = FIN;
                end else begin
                    estado_d = CAMBIO;
                end
            end
            CAMBIO: begin
                jugador_d  = ~jugador_q;
                cargar_tmr = 1'b1;
                estado_d   = TURNO;
            end
            FIN: begin
                if (start_juego) begin
                    estado_d = INICIALIZAR;
                end
            end
            default: begin
                estado_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q  <= IDLE;
            jugador_q <= 1'b0;
            num_q     <= '0;
            ganador_q <= GANADOR_NINGUNO;
            timeout_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            jugador_q <= jugador_d;
            num_q     <= num_d;
            ganador_q <= ganador_d;
            timeout_q <= timeout_d;
        end
    end

    assign start_inicial    = (estado_q == INICIALIZAR);
    assign habilitar_jugada = (estado_q == TURNO);
    assign fin_juego        = (estado_q == FIN);
    assign jugador_actual   = jugador_q;
    assign num_jugadas      = num_q;
    assign ganador          = ganador_q;
    assign timeout          = timeout_q;

endmodule

// File: tb/tb_controlador_turnos.sv
module tb_controlador_turnos;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_juego = 1'b0;
    logic       start_inicial;
    logic       listo = 1'b0;
    logic       jugador_inicial = 1'b0;
    logic       jugada_hecha = 1'b0;
    logic       hay_ganador = 1'b0;
    logic       tablero_lleno = 1'b0;
    logic       jugador_actual;
    logic       habilitar_jugada;
    logic [1:0] segundos_restantes;
    logic       timeout;
    logic [6:0] num_jugadas;
    logic       fin_juego;
    logic [1:0] ganador;

    int n_tests = 0;
    int n_fail  = 0;

    controlador_turnos #(
        .CICLOS_POR_SEG (4),
        .SEGUNDOS_TURNO (3)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .start_juego        (start_juego),
        .start_inicial      (start_inicial),
        .listo              (listo),
        .jugador_inicial    (jugador_inicial),
        .jugada_hecha       (jugada_hecha),
        .hay_ganador        (hay_ganador),
        .tablero_lleno      (tablero_lleno),
        .jugador_actual     (jugador_actual),
        .habilitar_jugada   (habilitar_jugada),
        .segundos_restantes (segundos_restantes),
        .timeout            (timeout),
        .num_jugadas        (num_jugadas),
        .fin_juego          (fin_juego),
        .ganador            (ganador)
    );

    always #5 clk = ~clk;

    task automatic paso();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reposo(input string tag);
        chk({tag, " start_inicial"},    32'(start_inicial),      32'd0);
        chk({tag, " jugador_actual"},   32'(jugador_actual),     32'd0);
        chk({tag, " habilitar_jugada"}, 32'(habilitar_jugada),   32'd0);
        chk({tag, " segundos"},         32'(segundos_restantes), 32'd0);
        chk({tag, " timeout"},          32'(timeout),            32'd0);
        chk({tag, " num_jugadas"},      32'(num_jugadas),        32'd0);
        chk({tag, " fin_juego"},        32'(fin_juego),          32'd0);
        chk({tag, " ganador"},          32'(ganador),            32'd0);
    endtask

    initial begin
        // Asynchronous reset before any clock edge
        #1 reset = 1'b1;
        #1 chk_reposo("reset");
        paso();
        paso();
        reset = 1'b0;
        paso();
        chk("idle habilitar", 32'(habilitar_jugada), 32'd0);

        // New game, player 1 starts
        jugador_inicial = 1'b1;
        start_juego = 1'b1;
        paso();
        start_juego = 1'b0;
        chk("start_inicial pulse", 32'(start_inicial), 32'd1);
        paso();
        chk("espera start_inicial 0", 32'(start_inicial), 32'd0);
        chk("espera habilitar", 32'(habilitar_jugada), 32'd0);
        paso();
        chk("espera start_inicial 1", 32'(start_inicial), 32'd0);
        paso();
        chk("espera start_inicial 2", 32'(start_inicial), 32'd0);
        listo = 1'b1;
        paso();
        listo = 1'b0;
        chk("turno habilitar", 32'(habilitar_jugada), 32'd1);
        chk("turno jugador", 32'(jugador_actual), 32'd1);
        chk("turno segundos", 32'(segundos_restantes), 32'd3);
        chk("turno num", 32'(num_jugadas), 32'd0);

        // No move: 3,3,3,3,2,2,2,2,1,1,1,1 then 0 with timeout
        for (int k = 1; k < 12; k++) begin
            paso();
            chk("cuenta segundos", 32'(segundos_restantes), 32'(3 - k / 4));
            chk("cuenta timeout", 32'(timeout), 32'd0);
        end
        paso();
        chk("expira segundos", 32'(segundos_restantes), 32'd0);
        chk("expira timeout", 32'(timeout), 32'd1);
        chk("expira habilitar", 32'(habilitar_jugada), 32'd0);
        chk("expira jugador", 32'(jugador_actual), 32'd1);
        paso();
        chk("tras timeout pulso", 32'(timeout), 32'd0);
        chk("tras timeout jugador", 32'(jugador_actual), 32'd0);
        chk("tras timeout segundos", 32'(segundos_restantes), 32'd3);
        chk("tras timeout habilitar", 32'(habilitar_jugada), 32'd1);
        chk("tras timeout num", 32'(num_jugadas), 32'd0);

        // Move on the exact cycle of the expiring tick
        for (int k = 1; k < 12; k++) paso();
        chk("limite segundos", 32'(segundos_restantes), 32'd1);
        jugada_hecha = 1'b1;
        paso();
        jugada_hecha = 1'b0;
        chk("limite timeout", 32'(timeout), 32'd0);
        chk("limite num", 32'(num_jugadas), 32'd1);
        chk("verificar habilitar", 32'(habilitar_jugada), 32'd0);
        paso();
        chk("cambio timeout", 32'(timeout), 32'd0);
        chk("cambio jugador", 32'(jugador_actual), 32'd0);
        paso();
        chk("turno j1 jugador", 32'(jugador_actual), 32'd1);
        chk("turno j1 segundos", 32'(segundos_restantes), 32'd3);
        chk("turno j1 habilitar", 32'(habilitar_jugada), 32'd1);

        // Player 1 moves, no result
        jugada_hecha = 1'b1;
        paso();
        jugada_hecha = 1'b0;
        paso();
        paso();
        chk("turno j0 jugador", 32'(jugador_actual), 32'd0);
        chk("turno j0 num", 32'(num_jugadas), 32'd2);
        chk("turno j0 fin", 32'(fin_juego), 32'd0);

        // Player 0 moves, win and full board together: win has priority
        jugada_hecha = 1'b1;
        hay_ganador = 1'b1;
        tablero_lleno = 1'b1;
        paso();
        jugada_hecha = 1'b0;
        chk("gana num", 32'(num_jugadas), 32'd3);
        paso();
        hay_ganador = 1'b0;
        tablero_lleno = 1'b0;
        chk("fin fin_juego", 32'(fin_juego), 32'd1);
        chk("fin ganador", 32'(ganador), 32'd1);
        chk("fin habilitar", 32'(habilitar_jugada), 32'd0);
        chk("fin jugador", 32'(jugador_actual), 32'd0);

        // A move in FIN is ignored
        jugada_hecha = 1'b1;
        paso();
        jugada_hecha = 1'b0;
        paso();
        chk("fin ignora ganador", 32'(ganador), 32'd1);
        chk("fin ignora num", 32'(num_jugadas), 32'd3);
        chk("fin ignora jugador", 32'(jugador_actual), 32'd0);
        chk("fin ignora fin_juego", 32'(fin_juego), 32'd1);
        chk("fin ignora segundos", 32'(segundos_restantes), 32'd3);
        chk("fin ignora timeout", 32'(timeout), 32'd0);

        // Restart from FIN, player 0 starts
        jugador_inicial = 1'b0;
        start_juego = 1'b1;
        paso();
        start_juego = 1'b0;
        chk("reinicio start_inicial", 32'(start_inicial), 32'd1);
        paso();
        chk("reinicio ganador", 32'(ganador), 32'd0);
        chk("reinicio num", 32'(num_jugadas), 32'd0);
        chk("reinicio fin_juego", 32'(fin_juego), 32'd0);
        chk("reinicio pulso unico", 32'(start_inicial), 32'd0);
        paso();
        paso();
        listo = 1'b1;
        paso();
        listo = 1'b0;
        chk("reinicio jugador", 32'(jugador_actual), 32'd0);
        chk("reinicio segundos", 32'(segundos_restantes), 32'd3);
        chk("reinicio habilitar", 32'(habilitar_jugada), 32'd1);

        // Move, then reset mid-TURNO between clock edges
        jugada_hecha = 1'b1;
        paso();
        jugada_hecha = 1'b0;
        paso();
        paso();
        for (int k = 0; k < 5; k++) paso();
        chk("pre reset jugador", 32'(jugador_actual), 32'd1);
        chk("pre reset segundos", 32'(segundos_restantes), 32'd2);
        chk("pre reset num", 32'(num_jugadas), 32'd1);
        #3 reset = 1'b1;
        #1 chk_reposo("reset async");
        paso();
        reset = 1'b0;
        paso();
        chk("post reset habilitar", 32'(habilitar_jugada), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
